keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter BOUNCE_CYCLES, default 64, length of each contact-bounce phase in clocks (0 = no bounce phases).
REQ-002 SHALL have parameter BOUNCE_PERIOD, default 4, clocks between contact toggles during bounce (min 1).
REQ-003 SHALL have parameter GAP_CYCLES, default 256, released time after each press before the next is accepted (min 1).
REQ-004 clk5  input  1  system clock (5 MHz); single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 press_valid  input  1  request to emulate one key press.
REQ-007 press_code  input  5  key to press: [4:3] row index, [2:0] column index.
REQ-008 press_hold  input  16  stable-closed duration in clocks; 0 treated as 1.
REQ-009 press_ready  output  1  high when a new request can be accepted.
REQ-010 press_done  output  1  one-cycle pulse when a press sequence, including gap, completes.
REQ-011 press_err  output  1  one-cycle pulse when an invalid code is accepted.
REQ-012 kprow  input  4  row drive from the keypad scanner, active low.
REQ-013 kpcol  output  6  column sense to the keypad scanner, active low (1 = open).

Function
REQ-014 Transfer SHALL occur on a cycle with press_valid=1 and press_ready=1; press_code and press_hold are captured on that cycle.
REQ-015 press_ready SHALL be 1 only in state IDLE; press_valid outside IDLE is ignored, no queuing.
REQ-016 Code with column index 6 or 7 SHALL be invalid: transfer completes, press_err pulses the next cycle, state stays IDLE, contact stays open.
REQ-017 FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-018 IDLE -> BOUNCE_IN on valid transfer; BOUNCE_IN -> HOLD after BOUNCE_CYCLES clocks; HOLD -> BOUNCE_OUT after press_hold clocks; BOUNCE_OUT -> GAP after BOUNCE_CYCLES clocks; GAP -> IDLE after GAP_CYCLES clocks.
REQ-019 BOUNCE_CYCLES=0 SHALL bypass BOUNCE_IN and BOUNCE_OUT (IDLE -> HOLD, HOLD -> GAP).
REQ-020 Internal contact SHALL be: 0 in IDLE and GAP; 1 in HOLD; in BOUNCE_IN start at 1 on the first cycle, toggle every BOUNCE_PERIOD clocks; in BOUNCE_OUT start at 0, toggle every BOUNCE_PERIOD clocks.
REQ-021 First cycle of BOUNCE_IN (or HOLD) SHALL be the cycle after the transfer.
REQ-022 kpcol[c] SHALL be 0 iff contact=1, c equals the captured column, and kprow[r]=0 for the captured row r; all other bits 1. Combinational from kprow and registered state only.
REQ-023 Other kprow bits SHALL not affect kpcol; several rows driven low at once are legal.
REQ-024 press_done and press_ready SHALL both assert on the cycle after the last GAP cycle; total sequence = 2*BOUNCE_CYCLES + hold + GAP_CYCLES clocks after transfer.
REQ-025 Phase counters SHALL be 16 bits wide, count down to 1, never wrap; press_hold = 65535 SHALL give exactly 65535 HOLD cycles.

Reset
REQ-026 On reset: state IDLE, contact 0, kpcol = 6'b111111, press_ready = 1 (from the first cycle after reset), press_done = 0, press_err = 0, counters 0.
REQ-027 Reset asserted mid-sequence SHALL abort the press; kpcol all ones from the next cycle, no press_done.

Structure
REQ-028 Shared package keypad_pkg SHALL hold KP_ROWS=4, KP_COLS=6, KEYCODE_W=5, row/column field positions, and the FSM state enumeration.
REQ-029 One sub-module kp_phase_counter (load value, decrement, last-cycle flag) SHALL implement all phase timing; toggle timing uses a separate small counter in the top.

Verification
REQ-030 BOUNCE_CYCLES=8, BOUNCE_PERIOD=2, GAP_CYCLES=16; transfer code 5'b01010, hold 100 at cycle N, kprow=4'b1101 -> kpcol toggles between 6'b111011 and 6'b111111 every 2 cycles in N+1..N+8, 6'b111011 in N+9..N+108, toggles in N+109..N+116, 6'b111111 in N+117..N+132, press_done and press_ready high at N+133.
REQ-031 Same press, kprow=4'b1110 throughout -> kpcol stays 6'b111111, timing of press_done unchanged.
REQ-032 Invalid code 5'b00110 -> press_err pulses at N+1, press_ready stays 1, kpcol stays 6'b111111.
REQ-033 BOUNCE_CYCLES=0, hold 0 -> kpcol low on the selected column for exactly 1 cycle at N+1, press_done at N+2+GAP_CYCLES.
REQ-034 Reset asserted during HOLD -> kpcol 6'b111111 next cycle, press_ready=1, no press_done; new transfer accepted afterward.
REQ-035 press_valid held high during a sequence with a different code -> ignored; the next transfer occurs only on the press_ready cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, key-code field layout and FSM states for the keypad emulator.
package keypad_pkg;
   localparam int KP_ROWS   = 4;
   localparam int KP_COLS   = 6;
   localparam int KEYCODE_W = 5;
   localparam int ROW_MSB   = 4;
   localparam int ROW_LSB   = 3;
   localparam int COL_MSB   = 2;
   localparam int COL_LSB   = 0;
   localparam int CNT_W     = 16;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      BOUNCE_IN  = 3'd1,
      HOLD       = 3'd2,
      BOUNCE_OUT = 3'd3,
      GAP        = 3'd4
   } kp_state_e;

   // Column indices 6 and 7 fit in the field but have no physical column.
   function automatic logic col_valid(input logic [COL_MSB-COL_LSB:0] col);
      return col < 3'(KP_COLS);
   endfunction
endpackage

// File: rtl/kp_phase_counter.sv
// Down-counter for phase timing: loads a length, counts down to 1 and flags the last cycle.
module kp_phase_counter
   import keypad_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         last
);
   logic [W-1:0] count;

   // Holds at 0 once expired so a long idle never wraps back to all ones.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign last = (count == W'(1));
endmodule

// File: rtl/keypad_emulator.sv
// Emulates one key press at a time on a row-scanned keypad, including contact bounce and a release gap.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int BOUNCE_CYCLES = 64,
   parameter int BOUNCE_PERIOD = 4,
   parameter int GAP_CYCLES    = 256
) (
   input  logic                 clk5,
   input  logic                 reset,
   input  logic                 press_valid,
   input  logic [KEYCODE_W-1:0] press_code,
   input  logic [CNT_W-1:0]     press_hold,
   output logic                 press_ready,
   output logic                 press_done,
   output logic                 press_err,
   input  logic [KP_ROWS-1:0]   kprow,
   output logic [KP_COLS-1:0]   kpcol,
   output kp_state_e            fsm_state
);
   // Handshake: a request transfers on any cycle with press_valid && press_ready;
   // press_ready is high only in IDLE and nothing is queued while busy.
   localparam int   TOG_W    = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
   localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(BOUNCE_PERIOD - 1);
   localparam logic NO_BOUNCE = (BOUNCE_CYCLES == 0);

   kp_state_e                  state;
   logic                       contact;
   logic [ROW_MSB-ROW_LSB:0]   row_q;
   logic [COL_MSB-COL_LSB:0]   col_q;
   logic [CNT_W-1:0]           hold_q;
   logic [CNT_W-1:0]           hold_eff;
   logic [TOG_W-1:0]           tog_cnt;
   logic                       accept;
   logic                       code_ok;
   logic                       phase_load;
   logic [CNT_W-1:0]           phase_value;
   logic                       phase_last;

   assign hold_eff = (press_hold == '0) ? CNT_W'(1) : press_hold;
   assign accept   = press_valid && press_ready && (state == IDLE);
   assign code_ok  = col_valid(press_code[COL_MSB:COL_LSB]);

   // Each phase boundary reloads the counter with the length of the phase being entered.
   always_comb begin
      phase_load  = 1'b0;
      phase_value = '0;
      case (state)
         IDLE: if (accept && code_ok) begin
            phase_load  = 1'b1;
            phase_value = NO_BOUNCE ? hold_eff : CNT_W'(BOUNCE_CYCLES);
         end
         BOUNCE_IN: if (phase_last) begin
            phase_load  = 1'b1;
            phase_value = hold_q;
         end
         HOLD: if (phase_last) begin
            phase_load  = 1'b1;
            phase_value = NO_BOUNCE ? CNT_W'(GAP_CYCLES) : CNT_W'(BOUNCE_CYCLES);
         end
         BOUNCE_OUT: if (phase_last) begin
            phase_load  = 1'b1;
            phase_value = CNT_W'(GAP_CYCLES);
         end
         default: ;
      endcase
   end

   kp_phase_counter #(.W(CNT_W)) u_phase (
      .clk        (clk5),
      .reset      (reset),
      .load       (phase_load),
      .load_value (phase_value),
      .last       (phase_last)
   );

   always_ff @(posedge clk5) begin
      if (reset) begin
         state       <= IDLE;
         contact     <= 1'b0;
         press_ready <= 1'b1;
         press_done  <= 1'b0;
         press_err   <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         hold_q      <= '0;
         tog_cnt     <= '0;
      end else begin
         press_done <= 1'b0;
         press_err  <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               if (!code_ok) begin
                  press_err <= 1'b1;
               end else begin
                  row_q       <= press_code[ROW_MSB:ROW_LSB];
                  col_q       <= press_code[COL_MSB:COL_LSB];
                  hold_q      <= hold_eff;
                  contact     <= 1'b1;
                  tog_cnt     <= '0;
                  press_ready <= 1'b0;
                  state       <= NO_BOUNCE ? HOLD : BOUNCE_IN;
               end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
               if (phase_last) begin
                  contact <= (state == BOUNCE_IN);
                  state   <= (state == BOUNCE_IN) ? HOLD : GAP;
               end else if (tog_cnt == TOG_LAST) begin
                  tog_cnt <= '0;
                  contact <= ~contact;
               end else begin
                  tog_cnt <= tog_cnt + 1'b1;
               end
            end
            HOLD: if (phase_last) begin
               contact <= 1'b0;
               tog_cnt <= '0;
               state   <= NO_BOUNCE ? GAP : BOUNCE_OUT;
            end
            GAP: if (phase_last) begin
               press_ready <= 1'b1;
               press_done  <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Contact only closes the selected column while the scanner drives its row low.
   always_comb begin
      kpcol = '1;
      for (int c = 0; c < KP_COLS; c++)
         if (contact && (col_q == 3'(c)) && !kprow[row_q])
            kpcol[c] = 1'b0;
   end

   assign fsm_state = state;
endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a per-cycle expected-output queue built from a timing model of each press.
module tb_keypad_emulator;
   import keypad_pkg::*;

   localparam int BC  = 8;
   localparam int BP  = 2;
   localparam int GAP = 16;

   logic        clk5 = 1'b0;
   logic        reset = 1'b1;
   logic        press_valid = 1'b0;
   logic        press_valid_nb = 1'b0;
   logic [4:0]  press_code = '0;
   logic [15:0] press_hold = '0;
   logic [3:0]  kprow = 4'b1111;
   logic        press_ready, press_done, press_err;
   logic        press_ready_nb, press_done_nb, press_err_nb;
   logic [5:0]  kpcol, kpcol_nb;
   kp_state_e   fsm_state, fsm_state_nb;

   int n_assert = 0;
   int n_fail   = 0;

   // Expected {err, done, ready, kpcol} per cycle after a transfer.
   logic [8:0] exp_q[$];

   always #5 clk5 = ~clk5;

   keypad_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_PERIOD(BP), .GAP_CYCLES(GAP)) dut (
      .clk5(clk5), .reset(reset), .press_valid(press_valid), .press_code(press_code),
      .press_hold(press_hold), .press_ready(press_ready), .press_done(press_done),
      .press_err(press_err), .kprow(kprow), .kpcol(kpcol), .fsm_state(fsm_state));

   keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(BP), .GAP_CYCLES(GAP)) dut_nb (
      .clk5(clk5), .reset(reset), .press_valid(press_valid_nb), .press_code(press_code),
      .press_hold(press_hold), .press_ready(press_ready_nb), .press_done(press_done_nb),
      .press_err(press_err_nb), .kprow(kprow), .kpcol(kpcol_nb), .fsm_state(fsm_state_nb));

   task automatic tick();
      @(posedge clk5);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Timing model: k counts cycles after the transfer; done/ready come at k = total+1.
   function automatic void push_press(input int bc, input int bp, input int gap,
                                      input logic [4:0] code, input int hold, input logic [3:0] rows);
      int h, total;
      bit c;
      logic [5:0] col_v;
      h = (hold == 0) ? 1 : hold;
      total = 2 * bc + h + gap;
      for (int k = 1; k <= total + 1; k++) begin
         if (k <= bc)               c = (((k - 1) / bp) % 2) == 0;
         else if (k <= bc + h)      c = 1'b1;
         else if (k <= 2 * bc + h)  c = (((k - bc - h - 1) / bp) % 2) == 1;
         else                       c = 1'b0;
         col_v = 6'b111111;
         if (c && rows[code[4:3]] == 1'b0) col_v[code[2:0]] = 1'b0;
         exp_q.push_back({1'b0, (k == total + 1), (k == total + 1), col_v});
      end
   endfunction

   task automatic check_seq(input string tag, input bit nb);
      int k = 1;
      logic [8:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (nb) check($sformatf("%s[%0d]", tag, k), {press_err_nb, press_done_nb, press_ready_nb, kpcol_nb}, e);
         else    check($sformatf("%s[%0d]", tag, k), {press_err, press_done, press_ready, kpcol}, e);
         k++;
         tick();
      end
   endtask

   task automatic start_press(input logic [4:0] code, input logic [15:0] hold);
      check("ready_before_transfer", press_ready, 1'b1);
      press_code  = code;
      press_hold  = hold;
      press_valid = 1'b1;
      tick();
      press_valid = 1'b0;
   endtask

   initial begin
      int done_seen;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("reset_ready", press_ready, 1'b1);
      check("reset_kpcol", kpcol, 6'b111111);
      check("reset_done", press_done, 1'b0);
      check("reset_err", press_err, 1'b0);
      check("reset_state", fsm_state, IDLE);

      // Normal press with the scanner on the matching row.
      kprow = 4'b1101;
      start_press(5'b01010, 16'd100);
      push_press(BC, BP, GAP, 5'b01010, 100, 4'b1101);
      check_seq("press_row_match", 1'b0);

      // Same press while a different row is scanned: column never pulled low.
      kprow = 4'b1110;
      start_press(5'b01010, 16'd100);
      push_press(BC, BP, GAP, 5'b01010, 100, 4'b1110);
      check_seq("press_row_other", 1'b0);

      // Invalid column: error pulse only, emulator stays idle.
      kprow = 4'b0000;
      start_press(5'b00110, 16'd10);
      exp_q.push_back({1'b1, 1'b0, 1'b1, 6'b111111});
      exp_q.push_back({1'b0, 1'b0, 1'b1, 6'b111111});
      check_seq("invalid_code", 1'b0);
      check("invalid_state", fsm_state, IDLE);

      // No-bounce build, hold 0 treated as one cycle.
      kprow = 4'b0111;
      press_code = 5'b11101;
      press_hold = 16'd0;
      press_valid_nb = 1'b1;
      tick();
      press_valid_nb = 1'b0;
      push_press(0, BP, GAP, 5'b11101, 0, 4'b0111);
      check_seq("no_bounce", 1'b1);

      // Reset during HOLD aborts the press.
      kprow = 4'b1101;
      start_press(5'b01010, 16'd100);
      repeat (19) tick();
      check("abort_in_hold", fsm_state, HOLD);
      check("abort_kpcol_before", kpcol, 6'b111011);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_kpcol", kpcol, 6'b111111);
      check("abort_ready", press_ready, 1'b1);
      check("abort_done", press_done, 1'b0);
      done_seen = 0;
      for (int i = 0; i < 150; i++) begin
         if (press_done) done_seen++;
         tick();
      end
      check("abort_no_done", done_seen, 0);
      start_press(5'b01010, 16'd3);
      push_press(BC, BP, GAP, 5'b01010, 3, 4'b1101);
      check_seq("after_abort", 1'b0);

      // press_valid held high with another code: only taken on the ready cycle.
      kprow = 4'b0000;
      check("held_ready", press_ready, 1'b1);
      press_code  = 5'b00001;
      press_hold  = 16'd20;
      press_valid = 1'b1;
      tick();
      press_code = 5'b10100;
      press_hold = 16'd5;
      push_press(BC, BP, GAP, 5'b00001, 20, 4'b0000);
      check_seq("held_first", 1'b0);
      press_valid = 1'b0;
      push_press(BC, BP, GAP, 5'b10100, 5, 4'b0000);
      check_seq("held_second", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
